// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing one XADC DRP port among NUM_REQ requesters, one DEN in flight.
// Optional: define XADC_DRP_TIMEOUT_EN to abort a stalled WAIT with rsp_err after TIMEOUT_CYCLES.
module xadc_drp_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0]      req_we,
   input  logic [7*NUM_REQ-1:0]    req_addr,
   input  logic [16*NUM_REQ-1:0]   req_di,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic [NUM_REQ-1:0]      rsp_valid,
   output logic [15:0]             rsp_data,
   output logic                    rsp_err,
   output logic                    drp_den,
   output logic                    drp_dwe,
   output logic [6:0]              drp_daddr,
   output logic [15:0]             drp_di,
   input  logic [15:0]             drp_do,
   input  logic                    drp_drdy
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t             state_reg;
   logic [GW-1:0]      last_grant_reg;
   logic [GW-1:0]      grant_reg;

   logic [6:0]         addr_slice [NUM_REQ];
   logic [15:0]        di_slice   [NUM_REQ];
   logic [NUM_REQ-1:0] rot_req;
   logic [GW:0]        shamt;
   logic [GW:0]        pick_sum;
   logic [GW-1:0]      pick_off;
   logic [GW-1:0]      pick;

   generate
      if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
         $error("xadc_drp_arbiter: parameter out of range");
      end
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign addr_slice[gi] = req_addr[7*gi +: 7];
         assign di_slice[gi]   = req_di[16*gi +: 16];
      end
   endgenerate

   // Rotate the request vector so bit 0 is the requester after last_grant;
   // the lowest set bit of the rotated vector is the winner's offset.
   always_comb begin
      shamt    = {1'b0, last_grant_reg} + (GW+1)'(1);
      rot_req  = NUM_REQ'({req_valid, req_valid} >> shamt);
      pick_off = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (rot_req[j]) pick_off = GW'(j);
      end
      pick_sum = shamt + {1'b0, pick_off};
      if (pick_sum >= (GW+1)'(NUM_REQ)) pick_sum = pick_sum - (GW+1)'(NUM_REQ);
      pick = pick_sum[GW-1:0];
   end

`ifdef XADC_DRP_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CW-1:0] wait_cnt_reg;
   logic          rsp_err_reg;
   assign rsp_err = rsp_err_reg;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= GW'(NUM_REQ - 1);
         grant_reg      <= '0;
         req_ready      <= '0;
         rsp_valid      <= '0;
         rsp_data       <= '0;
         drp_den        <= 1'b0;
         drp_dwe        <= 1'b0;
         drp_daddr      <= '0;
         drp_di         <= '0;
`ifdef XADC_DRP_TIMEOUT_EN
         wait_cnt_reg   <= '0;
         rsp_err_reg    <= 1'b0;
`endif
      end else begin
         // Strobes default low; drp_daddr/drp_di/rsp_data hold between updates.
         req_ready <= '0;
         rsp_valid <= '0;
         drp_den   <= 1'b0;
         drp_dwe   <= 1'b0;
`ifdef XADC_DRP_TIMEOUT_EN
         rsp_err_reg <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (|req_valid) begin
                  grant_reg <= pick;
                  req_ready <= NUM_REQ'(1) << pick;
                  drp_den   <= 1'b1;
                  drp_dwe   <= req_we[pick];
                  drp_daddr <= addr_slice[pick];
                  drp_di    <= di_slice[pick];
                  state_reg <= WAIT;
`ifdef XADC_DRP_TIMEOUT_EN
                  wait_cnt_reg <= '0;
`endif
               end
            end
            WAIT: begin
               if (drp_drdy) begin
                  rsp_valid      <= NUM_REQ'(1) << grant_reg;
                  rsp_data       <= drp_do;
                  last_grant_reg <= grant_reg;
                  state_reg      <= IDLE;
               end
`ifdef XADC_DRP_TIMEOUT_EN
               else if (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_valid      <= NUM_REQ'(1) << grant_reg;
                  rsp_data       <= '0;
                  rsp_err_reg    <= 1'b1;
                  last_grant_reg <= grant_reg;
                  state_reg      <= IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + CW'(1);
               end
`endif
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Bench for xadc_drp_arbiter: transaction-level reference model checked every cycle, plus directed
// scenarios with hand-computed literal expectations. Honours XADC_DRP_TIMEOUT_EN when defined.
module tb_xadc_drp_arbiter;
   localparam int NR = 3;
   localparam int TO = 16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic [NR-1:0]      req_valid = '0;
   logic [NR-1:0]      req_we = '0;
   logic [7*NR-1:0]    req_addr = '0;
   logic [16*NR-1:0]   req_di = '0;
   logic [NR-1:0]      req_ready;
   logic [NR-1:0]      rsp_valid;
   logic [15:0]        rsp_data;
   logic               rsp_err;
   logic               drp_den;
   logic               drp_dwe;
   logic [6:0]         drp_daddr;
   logic [15:0]        drp_di;
   logic [15:0]        drp_do = '0;
   logic               drp_drdy = 1'b0;

   int nchk = 0;
   int nerr = 0;

   xadc_drp_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_di(req_di),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
      .drp_do(drp_do), .drp_drdy(drp_drdy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   logic [NR-1:0] e_ready = '0, e_rsp_valid = '0;
   logic [15:0]   e_rsp_data = '0, e_di = '0;
   logic          e_rsp_err = 1'b0, e_den = 1'b0, e_dwe = 1'b0;
   logic [6:0]    e_daddr = '0;
   bit            m_busy = 1'b0;
   int            m_last = NR - 1;
   int            m_owner = 0;
   int            m_waited = 0;

   function automatic int next_owner(input int last, input logic [NR-1:0] v);
      for (int k = 1; k <= NR; k++) begin
         if (v[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_last = NR - 1; m_waited = 0;
         e_ready = '0; e_rsp_valid = '0; e_rsp_data = '0; e_rsp_err = 1'b0;
         e_den = 1'b0; e_dwe = 1'b0; e_daddr = '0; e_di = '0;
      end else begin
         e_ready = '0; e_rsp_valid = '0; e_rsp_err = 1'b0; e_den = 1'b0; e_dwe = 1'b0;
         if (!m_busy) begin
            if (req_valid != '0) begin
               m_owner = next_owner(m_last, req_valid);
               e_ready[m_owner] = 1'b1;
               e_den   = 1'b1;
               e_dwe   = req_we[m_owner];
               e_daddr = req_addr[7*m_owner +: 7];
               e_di    = req_di[16*m_owner +: 16];
               m_busy = 1'b1; m_waited = 0;
            end
         end else begin
            m_waited++;
            if (drp_drdy) begin
               e_rsp_valid[m_owner] = 1'b1; e_rsp_data = drp_do;
               m_last = m_owner; m_busy = 1'b0;
            end
`ifdef XADC_DRP_TIMEOUT_EN
            else if (m_waited == TO) begin
               e_rsp_valid[m_owner] = 1'b1; e_rsp_data = '0; e_rsp_err = 1'b1;
               m_last = m_owner; m_busy = 1'b0;
            end
`endif
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit outstanding = 1'b0;
   always @(negedge clk) begin
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rsp_valid);
      chk("rsp_data", rsp_data, e_rsp_data);
      chk("rsp_err", rsp_err, e_rsp_err);
      chk("drp_den", drp_den, e_den);
      chk("drp_dwe", drp_dwe, e_dwe);
      chk("drp_daddr", drp_daddr, e_daddr);
      chk("drp_di", drp_di, e_di);
      if (!rst_n) outstanding = 1'b0;
      if (drp_den) begin
         chk("single_den_in_flight", outstanding, 1'b0);
         outstanding = 1'b1;
      end
      if (rsp_valid != '0) begin
         outstanding = 1'b0;
         $display("txn: rsp_valid=%b data=%h err=%b t=%0t", rsp_valid, rsp_data, rsp_err, $time);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic wait_ready(input int r, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (req_ready[r]) ok = 1'b1;
      end
      chk("wait_ready", ok, 1'b1);
   endtask

   task automatic wait_rsp(input int r, output int n);
      bit ok;
      ok = 1'b0; n = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (rsp_valid[r]) ok = 1'b1; else n++;
      end
      chk("wait_rsp", ok, 1'b1);
   endtask

   task automatic do_txn(input int r, input logic we, input logic [6:0] a, input logic [15:0] d,
                         input int lat, input logic [15:0] dout);
      bit ok;
      int n;
      req_we[r] = we; req_addr[7*r +: 7] = a; req_di[16*r +: 16] = d; req_valid[r] = 1'b1;
      wait_ready(r, ok);
      chk("txn_den", drp_den, 1'b1);
      chk("txn_dwe", drp_dwe, we);
      chk("txn_daddr", drp_daddr, a);
      chk("txn_di", drp_di, d);
      tick();
      req_valid[r] = 1'b0;
      repeat (lat - 1) tick();
      drp_drdy = 1'b1; drp_do = dout;
      tick();
      drp_drdy = 1'b0;
      wait_rsp(r, n);
      chk("rsp_latency", n, 0);
      chk("txn_rsp_data", rsp_data, dout);
      chk("txn_rsp_err", rsp_err, 1'b0);
   endtask

   task automatic grant_seq(input logic [NR-1:0] mask, input int exp_seq[4]);
      bit ok;
      int idx;
      req_we = '0;
      req_addr = {7'h22, 7'h11, 7'h0A};
      req_valid = mask;
      for (int i = 0; i < 4; i++) begin
         ok = 1'b0; idx = -1;
         for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            for (int j = 0; j < NR; j++) if (req_ready[j]) begin idx = j; ok = 1'b1; end
         end
         chk("grant_order", idx, exp_seq[i]);
         tick();
         if (i == 3) req_valid = '0;
         drp_drdy = 1'b1; drp_do = 16'h1000 + 16'(i);
         tick();
         drp_drdy = 1'b0;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic expect_quiet(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk(name, {req_ready, rsp_valid}, '0);
      end
   endtask

   int seq_two[4]   = '{0, 1, 0, 1};
   int seq_three[4] = '{2, 0, 1, 2};

   initial begin
      bit ok;
      int n;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {req_ready, rsp_valid, rsp_err, drp_den, drp_dwe, drp_daddr, drp_di}, '0);
      tick();
      rst_n = 1'b1;
      tick();

      // single read, then write
      do_txn(0, 1'b0, 7'h03, 16'h0000, 3, 16'hABC0);
      chk("daddr_hold", drp_daddr, 7'h03);
      do_txn(1, 1'b1, 7'h41, 16'h313F, 2, 16'h0000);

      // contention: two requesters, then three with wrap
      grant_seq(3'b011, seq_two);
      grant_seq(3'b111, seq_three);

      // spurious DRDY in IDLE
      drp_drdy = 1'b1; drp_do = 16'h1234;
      tick();
      drp_drdy = 1'b0;
      expect_quiet("spurious_drdy", 3);
      do_txn(0, 1'b0, 7'h10, 16'h0000, 2, 16'h5555);

      // stalled WAIT
      req_we[2] = 1'b0; req_addr[14 +: 7] = 7'h20; req_valid[2] = 1'b1;
      wait_ready(2, ok);
      tick();
      req_valid[2] = 1'b0;
`ifdef XADC_DRP_TIMEOUT_EN
      n = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid[2]) break;
         n++;
      end
      chk("timeout_cycles", n, TO);
      chk("timeout_err", rsp_err, 1'b1);
      chk("timeout_data", rsp_data, 16'h0000);
      tick();
      drp_drdy = 1'b1; drp_do = 16'hBEEF;
      tick();
      drp_drdy = 1'b0;
      expect_quiet("late_drdy", 3);
      // open a fresh transaction to interrupt with reset
      req_addr[7 +: 7] = 7'h05; req_valid[1] = 1'b1;
      wait_ready(1, ok);
      tick();
      req_valid[1] = 1'b0;
      tick();
`else
      req_addr[0 +: 7] = 7'h01; req_valid[0] = 1'b1;
      expect_quiet("wait_holds", 40);
      req_valid[0] = 1'b0;
      tick();
`endif
      // reset in the middle of WAIT
      rst_n = 1'b0;
      #1;
      chk("async_reset", {req_ready, rsp_valid, rsp_err, drp_den, drp_dwe, drp_daddr, drp_di, rsp_data}, '0);
      tick();
      rst_n = 1'b1;
      drp_drdy = 1'b1; drp_do = 16'h7777;
      tick();
      drp_drdy = 1'b0;
      expect_quiet("no_rsp_after_reset", 3);

      // fresh contention after reset: requester 0 first
      req_addr[0 +: 7] = 7'h30; req_addr[7 +: 7] = 7'h31; req_we = '0;
      req_valid[0] = 1'b1; req_valid[1] = 1'b1;
      wait_ready(0, ok);
      chk("post_reset_daddr", drp_daddr, 7'h30);
      tick();
      req_valid = '0;
      drp_drdy = 1'b1; drp_do = 16'h0042;
      tick();
      drp_drdy = 1'b0;
      wait_rsp(0, n);
      chk("post_reset_data", rsp_data, 16'h0042);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", nerr, nchk);
      $fatal(1);
   end
endmodule
